// File: rtl/seq_divider_pkg.sv
// Shared definitions for the signed/unsigned sequential divider.
//   state_t   : controller states (IDLE, CALC, FIX)
//   cnt_width : iteration counter width for a given operand width
//   lat_full  : edges from an accepted start to a normal-path result
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned lat_full(input int unsigned width);
    return width + 2;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step (combinational).
//   rem_in      : current partial remainder (always < divisor_mag)
//   bit_in      : next dividend bit, MSB first
//   divisor_mag : divisor magnitude
//   rem_out     : new partial remainder
//   q_bit       : quotient bit produced by this step
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    // Modulo-2^WIDTH subtract is exact whenever it is selected: the result
    // is then smaller than the divisor.
    diff    = shifted[WIDTH-1:0] - divisor_mag;
    q_bit   = (shifted >= {1'b0, divisor_mag});
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider_sgn.sv
// Multi-cycle integer divider with per-operation signed/unsigned mode.
//   clk, rst            : clock, synchronous active-high reset
//   start, is_signed    : request and mode, sampled while busy=0
//   dividend, divisor   : operands, captured with start
//   abort               : cancel the in-flight operation
//   busy                : operation in flight
//   quotient, remainder : result, held until the next accepted start
//   zeroErr, overflow   : divide-by-zero / signed MIN/-1 flags
//   valid               : outputs hold a completed result
// Zero-divisor, signed-overflow and cache-hit results complete one edge after
// start; the normal path takes WIDTH+2 edges.
module seq_divider_sgn
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CACHING  = 1,
  parameter bit          INIT_VLD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zeroErr,
  output logic             overflow,
  output logic             valid
);

  localparam int unsigned      CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fix_load;
  logic [WIDTH-1:0] a_sh, b_mag, rem, q_w, r_w;
  logic             neg_q, neg_r, zf, of;
  logic [WIDTH-1:0] op_dvd, op_dvs, c_dvd, c_dvs;
  logic             op_sgn, c_sgn, c_vld;

  logic             dvd_neg, dvs_neg, zero_in, ovf_in, hit;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_nxt;
  logic             q_bit;

  always_comb begin
    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
    zero_in = (divisor == '0);
    ovf_in  = is_signed & (dividend == MIN_VAL) & (divisor == '1);
    hit     = (CACHING != 0) & c_vld & (dividend == c_dvd) &
              (divisor == c_dvs) & (is_signed == c_sgn);
  end

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem),
    .bit_in      (a_sh[WIDTH-1]),
    .divisor_mag (b_mag),
    .rem_out     (rem_nxt),
    .q_bit       (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fix_load  <= 1'b0;
      a_sh      <= '0;
      b_mag     <= '0;
      rem       <= '0;
      q_w       <= '0;
      r_w       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zf        <= 1'b0;
      of        <= 1'b0;
      op_dvd    <= '0;
      op_dvs    <= '0;
      op_sgn    <= 1'b0;
      c_dvd     <= '0;
      c_dvs     <= '0;
      c_sgn     <= 1'b0;
      c_vld     <= INIT_VLD;
      busy      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      zeroErr   <= 1'b0;
      overflow  <= 1'b0;
      valid     <= INIT_VLD;
    end else if (busy && abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      c_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            op_dvd   <= dividend;
            op_dvs   <= divisor;
            op_sgn   <= is_signed;
            valid    <= 1'b0;
            zeroErr  <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            zf       <= zero_in;
            of       <= ~zero_in & ovf_in;
            // Short paths park the final result in q_w/r_w and go straight
            // to the load half of FIX.
            if (zero_in) begin
              q_w      <= '1;
              r_w      <= dividend;
              fix_load <= 1'b1;
              state    <= FIX;
            end else if (ovf_in) begin
              q_w      <= MIN_VAL;
              r_w      <= '0;
              fix_load <= 1'b1;
              state    <= FIX;
            end else if (hit) begin
              // A cached operation is always a normal-path result, so the
              // flags stay clear and the held outputs are already correct.
              q_w      <= quotient;
              r_w      <= remainder;
              fix_load <= 1'b1;
              state    <= FIX;
            end else begin
              a_sh  <= dvd_mag;
              b_mag <= dvs_mag;
              rem   <= '0;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          a_sh <= {a_sh[WIDTH-2:0], 1'b0};
          rem  <= rem_nxt;
          q_w  <= {q_w[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            fix_load <= 1'b0;
            state    <= FIX;
          end
        end
        FIX: begin
          if (!fix_load) begin
            // First FIX edge applies signs, second one loads the outputs.
            q_w      <= neg_q ? (~q_w + 1'b1) : q_w;
            r_w      <= neg_r ? (~rem + 1'b1) : rem;
            fix_load <= 1'b1;
          end else begin
            quotient  <= q_w;
            remainder <= r_w;
            zeroErr   <= zf;
            overflow  <= of;
            valid     <= 1'b1;
            busy      <= 1'b0;
            c_dvd     <= op_dvd;
            c_dvs     <= op_dvs;
            c_sgn     <= op_sgn;
            c_vld     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_sgn.sv
module tb_seq_divider_sgn;

  localparam int unsigned W = 32;
  localparam int unsigned LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, is_signed, abort;
  logic [W-1:0] dividend, divisor;
  logic         busy, zeroErr, overflow, valid;
  logic [W-1:0] quotient, remainder;

  always #5 clk = ~clk;

  seq_divider_sgn #(.WIDTH(W), .CACHING(1), .INIT_VLD(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .abort     (abort),
    .busy      (busy),
    .quotient  (quotient),
    .remainder (remainder),
    .zeroErr   (zeroErr),
    .overflow  (overflow),
    .valid     (valid)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        o;
    int unsigned lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // reference model state: last completed operation for the cache
  bit          m_cv = 1'b0;
  logic [31:0] m_a, m_b;
  bit          m_s;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t e;
    longint sa, sbv;
    e.tag = tag;
    e.z = 1'b0;
    e.o = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
      e.lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
      e.o = 1'b1;
      e.lat = 1;
    end else begin
      if (s) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.q = 32'(sa / sbv);
        e.r = 32'(sa % sbv);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      e.lat = (m_cv && m_a == a && m_b == b && m_s == s) ? 1 : LAT;
    end
    m_cv = 1'b1;
    m_a = a;
    m_b = b;
    m_s = s;
    return e;
  endfunction

  // monitor: pops and compares on each rising edge of valid
  int unsigned ncyc = 0;
  int unsigned t_busy = 0;
  logic prev_valid = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    ncyc++;
    if (busy && !prev_busy) t_busy = ncyc;
    if (valid && !prev_valid && !rst) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_q"}, quotient, e.q);
        chk({e.tag, "_r"}, remainder, e.r);
        chk({e.tag, "_zero"}, zeroErr, e.z);
        chk({e.tag, "_ovf"}, overflow, e.o);
        chk({e.tag, "_lat"}, ncyc - t_busy, e.lat);
        chk({e.tag, "_busy"}, busy, 0);
      end
    end
    prev_valid = valid;
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input string tag);
    wait_idle();
    sb.push_back(model(s, a, b, tag));
    start = 1'b1;
    is_signed = s;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    is_signed = 1'($urandom);
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, valid, 1);
    tick();
  endtask

  task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b, input string tag);
    issue(s, a, b, tag);
    wait_valid(tag);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    abort = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_zero", zeroErr, 0);
    chk("rst_ovf", overflow, 0);

    op(0, 32'h1000_0001, 32'h2000_0001, "u_small");
    op(0, 100, 7, "u_100_7");
    op(0, 100, 7, "u_100_7_hit");
    op(1, -32'sd7, 32'd2, "s_m7_2");
    op(1, 32'd7, -32'sd2, "s_7_m2");
    op(1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf");
    op(0, 32'h8000_0000, 32'hFFFF_FFFF, "u_big");
    op(0, 55, 0, "zero");
    op(0, 9, 3, "u_9_3");

    // start while busy is ignored
    issue(0, 12345, 67, "busy_ign");
    repeat (5) tick();
    start = 1'b1;
    dividend = 9;
    divisor = 4;
    tick();
    start = 1'b0;
    wait_valid("busy_ign");
    repeat (3) tick();
    chk("busy_ign_idle", busy, 0);

    // abort 10 cycles in, with a competing start in the same cycle
    issue(0, 1000, 3, "abort");
    repeat (9) tick();
    abort = 1'b1;
    start = 1'b1;
    dividend = 77;
    divisor = 5;
    tick();
    abort = 1'b0;
    start = 1'b0;
    void'(sb.pop_back());
    m_cv = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_q_kept", quotient, 12345 / 67);
    chk("abort_r_kept", remainder, 12345 % 67);
    repeat (3) tick();
    chk("abort_stays_idle", busy, 0);

    // abort together with start while idle: start blocked
    abort = 1'b1;
    start = 1'b1;
    dividend = 50;
    divisor = 5;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("idle_abort_blocks", busy, 0);

    op(0, 1000, 3, "reissue");

    // reset in the middle of CALC
    issue(1, 32'hDEAD_BEEF, 32'h1234, "mid_rst");
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    m_cv = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_q", quotient, 0);
    chk("mrst_r", remainder, 0);
    chk("mrst_zero", zeroErr, 0);
    chk("mrst_ovf", overflow, 0);
    repeat (50) tick();
    chk("mrst_no_valid", valid, 0);

    // randomized operations
    begin
      logic [31:0] a = 32'd1;
      logic [31:0] b = 32'd1;
      bit s = 1'b0;
      for (int i = 0; i < 40; i++) begin
        int unsigned sel = $urandom_range(0, 9);
        if (sel > 1 || i == 0) begin
          s = 1'($urandom);
          a = $urandom;
          case ($urandom_range(0, 3))
            0: b = $urandom_range(1, 20);
            1: b = -$urandom_range(1, 20);
            default: b = $urandom;
          endcase
          if (sel == 9) b = 32'd0;
          if (sel == 8) begin
            s = 1'b1;
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
          end
        end
        op(s, a, b, $sformatf("rnd%0d", i));
      end
    end

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider_sgn.md
Name: seq_divider_sgn

Overview:
- Parametrised multi-cycle integer divider; next generation of the team's unsigned `divider`.
- Adds per-operation signed/unsigned mode, a `busy` handshake, `abort`, and signed-overflow detection.
- Keeps WIDTH, CACHING and INIT_VLD, the `zeroErr`/`valid` semantics and the result-caching fast path.
- Sits beside the datapath as a start/valid slave; one operation in flight.

Parameters:
- WIDTH, 32: operand and result width in bits; legal range 4..64.
- CACHING, 1: 1 = a repeat of the last completed operand set returns in 1 cycle; 0 = always full latency.
- INIT_VLD, 0: reset value of `valid` (and of the cache-valid flag).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- is_signed  in  1  1 = two's-complement operands; captured with start.
- dividend  in  WIDTH  numerator; captured with start.
- divisor  in  WIDTH  denominator; captured with start.
- abort  in  1  cancels the in-flight operation.
- busy  out  1  high while an operation is in flight.
- quotient  out  WIDTH  result, held until the next accepted start.
- remainder  out  WIDTH  result, held until the next accepted start.
- zeroErr  out  1  last result was a divide-by-zero.
- overflow  out  1  last result was signed MIN / -1.
- valid  out  1  level signal: outputs hold a completed result.

Behaviour:
- Reset values: busy=0, quotient=0, remainder=0, zeroErr=0, overflow=0, valid=INIT_VLD, cache flag=INIT_VLD, state=IDLE.
- States:
  - IDLE: accepts start.
  - CALC: WIDTH iterations, one quotient bit per cycle.
  - FIX: sign correction and output register load.
- Accepted start, on edge E0:
  - Captures operands and mode.
  - Clears valid, zeroErr and overflow.
  - Sets busy.
- Zero divisor, detected at E0:
  - Next edge: quotient = all ones, remainder = dividend (unmodified), zeroErr=1, valid=1, busy=0.
  - Applies in both modes.
- Signed overflow (is_signed=1, dividend=MIN, divisor=-1), detected at E0:
  - Next edge: quotient=MIN, remainder=0, overflow=1, valid=1.
- Cache hit (CACHING=1, cache flag=1, operands and is_signed equal the last completed non-aborted operation):
  - Next edge: outputs re-asserted unchanged, valid=1.
- Normal path:
  - E0 stores |dividend| and |divisor| (magnitudes only when is_signed=1).
  - CALC runs restoring division, MSB first, for exactly WIDTH edges.
  - FIX negates the quotient if the operand signs differ.
  - FIX gives the remainder the sign of the dividend.
  - valid rises, and busy falls, on edge E0+WIDTH+2.
- Unsigned mode never sets overflow.
- Signed results truncate toward zero; remainder = dividend - quotient*divisor exactly.
- Completion (normal, zero or overflow path) stores the operand set and sets the cache flag.
- start while busy=1: ignored; no queueing.
- abort while busy=1:
  - Next edge: return to IDLE, busy=0, valid=0.
  - quotient and remainder keep their old values; cache flag cleared.
- abort with start in the same cycle: abort wins and start is ignored in every state.
- abort while idle: no effect apart from blocking start.
- rst mid-operation: full reset to the listed values on the next edge.
- Operand inputs may change freely after E0; only captured copies are used.

Decomposition:
- Package seq_divider_pkg:
  - state enum (IDLE, CALC, FIX);
  - function for the WIDTH-dependent counter width, $clog2(WIDTH+1);
  - localparam LAT_FULL = WIDTH+2.
- Sub-module div_iter_step: combinational one-bit restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
- The FSM, sign handling, cache and counter live in the top.

Test Plan:
- Unsigned, WIDTH=32, dividend=0x10000001, divisor=0x20000001 -> after 34 cycles: quotient=0, remainder=0x10000001, valid=1, zeroErr=0.
- Unsigned 100/7 -> q=14, r=2; repeat the same start -> valid after 1 cycle, same values.
- Signed, is_signed=1, -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
- Signed, 7/-2 -> q=-3, r=1.
- Signed, 0x80000000 / 0xFFFFFFFF -> 1 cycle later: q=0x80000000, r=0, overflow=1.
- Unsigned, 0x80000000 / 0xFFFFFFFF -> full latency: q=0, r=0x80000000, overflow=0.
- 55/0 -> 1 cycle later: zeroErr=1, q=0xFFFFFFFF, r=55.
- Next start 9/3 -> zeroErr=0, q=3, r=0.
- Start 1000/3; abort 10 cycles in -> busy=0, valid=0 next cycle; a second start pulsed during busy is ignored.
- Re-issue 1000/3 -> full 34-cycle latency (cache cleared); result q=333, r=1.
- rst asserted mid-CALC -> all outputs at reset values next edge; no stray valid afterwards.
